// File: rtl/gru_weight_loader.sv
// gru_weight_loader: validates a layer header, then streams bias, input-weight and recurrent-weight
// words into the GRU coefficient memories. Define GRU_LOADER_CHECKSUM_EN to require a trailing sum beat.
module gru_weight_loader #(
    parameter int         N        = 24,
    parameter int         M        = 24,
    parameter logic [7:0] LAYER_ID = 8'd1,
    parameter int         ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam logic [ADDR_W-1:0] BIAS_LAST  = ADDR_W'(3 * N - 1);
    localparam logic [ADDR_W-1:0] INPUT_LAST = ADDR_W'(3 * N * M - 1);
    localparam logic [ADDR_W-1:0] RECUR_LAST = ADDR_W'(3 * N * N - 1);

`ifdef GRU_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_BIAS, S_INPUT, S_RECUR, S_CHECK, S_DONE, S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_BIAS, S_INPUT, S_RECUR, S_DONE, S_ERROR
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_wr_en;
    logic [1:0]          r_wr_sel;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                w_in_load;
    logic                w_payload;
    logic                w_accept;
    logic                w_last;
    logic                w_hdr_ok;
    logic [1:0]          w_sel;
`ifdef GRU_LOADER_CHECKSUM_EN
    logic [31:0]         r_sum;
`endif

    always_comb begin
        w_in_load = 1'b0;
        w_payload = 1'b0;
        w_last    = 1'b0;
        w_sel     = 2'd0;
        case (r_state)
            S_HEADER: w_in_load = 1'b1;
            S_BIAS: begin
                w_in_load = 1'b1;
                w_payload = 1'b1;
                w_last    = (r_cnt == BIAS_LAST);
                w_sel     = 2'd0;
            end
            S_INPUT: begin
                w_in_load = 1'b1;
                w_payload = 1'b1;
                w_last    = (r_cnt == INPUT_LAST);
                w_sel     = 2'd1;
            end
            S_RECUR: begin
                w_in_load = 1'b1;
                w_payload = 1'b1;
                w_last    = (r_cnt == RECUR_LAST);
                w_sel     = 2'd2;
            end
`ifdef GRU_LOADER_CHECKSUM_EN
            S_CHECK: w_in_load = 1'b1;
`endif
            default: ;
        endcase
    end

    // A start pulse takes priority, so the beat offered alongside it is never consumed.
    assign s_ready  = w_in_load && !start;
    assign w_accept = s_valid && s_ready;
    assign w_hdr_ok = (s_data[31:16] == 16'hC0DE) && (s_data[15:8] == LAYER_ID);

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = S_HEADER;
        end else if (w_accept) begin
            case (r_state)
                S_HEADER: w_state_next = w_hdr_ok ? S_BIAS : S_ERROR;
                S_BIAS:   if (w_last) w_state_next = S_INPUT;
                S_INPUT:  if (w_last) w_state_next = S_RECUR;
`ifdef GRU_LOADER_CHECKSUM_EN
                S_RECUR:  if (w_last) w_state_next = S_CHECK;
                S_CHECK:  w_state_next = (s_data == r_sum) ? S_DONE : S_ERROR;
`else
                S_RECUR:  if (w_last) w_state_next = S_DONE;
`endif
                default:  w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= 2'd0;
            r_wr_addr <= '0;
            r_wr_data <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_wr_en <= w_accept && w_payload;
            if (w_accept && w_payload) begin
                r_wr_sel  <= w_sel;
                r_wr_addr <= r_cnt;
                r_wr_data <= s_data;
            end
            // One counter serves all regions; it wraps to 0 on each region's last word.
            if (start) begin
                r_cnt <= '0;
            end else if (w_accept && w_payload) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

`ifdef GRU_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= 32'd0;
        end else if (start) begin
            r_sum <= 32'd0;
        end else if (w_accept && w_payload) begin
            r_sum <= r_sum + s_data;
        end
    end
`endif

    assign wr_en   = r_wr_en;
    assign wr_sel  = r_wr_sel;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = w_in_load;
    assign done    = (r_state == S_DONE);
    assign error   = (r_state == S_ERROR);

endmodule

// File: tb/tb_gru_weight_loader.sv
// Scoreboard bench for gru_weight_loader: the driver queues expected writes, a monitor pops and compares.
// Honours GRU_LOADER_CHECKSUM_EN the same way as the design.
module tb_gru_weight_loader;
    localparam int N      = 24;
    localparam int M      = 24;
    localparam int ADDR_W = 16;
    localparam int NB     = 3 * N;
    localparam int NI     = 3 * N * M;
    localparam int NR     = 3 * N * N;
    localparam int NP     = NB + NI + NR;
    localparam logic [31:0] GOOD_SUM = 32'd6221628;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [31:0]       s_data = 32'd0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;

    typedef struct packed {
        logic [1:0]        sel;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    gru_weight_loader #(.N(N), .M(M), .LAYER_ID(8'd1), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    function automatic wr_t exp_of(input int k);
        wr_t e;
        e.data = 32'(k);
        if (k < NB) begin
            e.sel = 2'd0; e.addr = ADDR_W'(k);
        end else if (k < NB + NI) begin
            e.sel = 2'd1; e.addr = ADDR_W'(k - NB);
        end else begin
            e.sel = 2'd2; e.addr = ADDR_W'(k - NB - NI);
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write on the port must match the oldest queued beat, exactly one cycle after acceptance.
    initial begin
        wr_t e;
        logic pend;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) begin
                pend = (exp_q.size() != 0);
                total++;
                if (wr_en !== pend) begin
                    bad++;
                    $display("FAIL wr_en: got %b expected %b", wr_en, pend);
                    if (pend) void'(exp_q.pop_front());
                end else if (wr_en) begin
                    e = exp_q.pop_front();
                    total++;
                    if ({wr_sel, wr_addr, wr_data} !== e) begin
                        bad++;
                        $display("FAIL write: got sel=%0d addr=%0d data=%0h expected sel=%0d addr=%0d data=%0h",
                                 wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
                    end
                end
            end
        end
    end

    // Offer one beat; payload beats push their expected write when the handshake happens.
    task automatic send_beat(input logic [31:0] d, input bit pay, input int k);
        bit acc;
        int w;
        acc = 1'b0;
        w = 0;
        s_valid = 1'b1;
        s_data = d;
        while (!acc) begin
            @(negedge clk);
            if (s_ready) begin
                acc = 1'b1;
                if (pay) exp_q.push_back(exp_of(k));
            end
            step();
            if (!acc) begin
                w++;
                if (w > 20) begin
                    chk("beat_timeout", 32'(w), 32'd0);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        s_valid = 1'b1;
        s_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("s_ready_during_start", {31'd0, s_ready}, 32'd0);
        step();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("error_cleared", {31'd0, error}, 32'd0);
    endtask

    // Header + first nbeats payload words (word k = k); a full load also sends the checksum when enabled.
    task automatic load(input bit gaps, input int nbeats, input int cs_off);
        do_start();
        send_beat(32'hC0DE0100, 1'b0, 0);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && $urandom_range(0, 9) < 3) begin
                s_valid = 1'b0;
                step();
            end
            send_beat(32'(k), 1'b1, k);
        end
`ifdef GRU_LOADER_CHECKSUM_EN
        if (nbeats == NP) send_beat(GOOD_SUM + 32'(cs_off), 1'b0, 0);
`else
        if (cs_off != 0) chk("checksum_unsupported", 32'(cs_off), 32'd0);
`endif
        s_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_wr_en"},   {31'd0, wr_en},   32'd0);
        chk({tag, "_wr_sel"},  {30'd0, wr_sel},  32'd0);
        chk({tag, "_wr_addr"}, {16'd0, wr_addr}, 32'd0);
        chk({tag, "_wr_data"}, wr_data,          32'd0);
        chk({tag, "_busy"},    {31'd0, busy},    32'd0);
        chk({tag, "_done"},    {31'd0, done},    32'd0);
        chk({tag, "_error"},   {31'd0, error},   32'd0);
    endtask

    task automatic bad_header(input logic [31:0] hdr);
        do_start();
        send_beat(hdr, 1'b0, 0);
        chk("bad_hdr_error", {31'd0, error}, 32'd1);
        chk("bad_hdr_done",  {31'd0, done},  32'd0);
        chk("bad_hdr_busy",  {31'd0, busy},  32'd0);
        s_data = 32'h00000005;
        repeat (4) step();
        chk("bad_hdr_s_ready", {31'd0, s_ready}, 32'd0);
        chk("bad_hdr_error_held", {31'd0, error}, 32'd1);
        s_valid = 1'b0;
        $display("bad header %08h: error=%0d", hdr, error);
    endtask

    initial begin
        s_valid = 1'b1;
        s_data = 32'h12345678;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) step();
        chk("idle_s_ready", {31'd0, s_ready}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        s_valid = 1'b0;

        load(1'b0, NP, 0);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_error", {31'd0, error}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd0);
        step();
        chk("full_done_held", {31'd0, done}, 32'd1);
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        $display("full-rate load: done=%0d", done);

        bad_header(32'hBEEF0100);
        bad_header(32'hC0DE0200);

        load(1'b1, NP, 0);
        chk("gaps_done", {31'd0, done}, 32'd1);
        step();
        $display("gapped load: done=%0d", done);

        load(1'b0, 100, 0);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        load(1'b0, NP, 0);
        chk("restart_done", {31'd0, done}, 32'd1);
        step();
        $display("aborted then reloaded: done=%0d", done);

        load(1'b0, 500, 0);
        s_valid = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        #3;
        chk_all_zero("midload_rst");
        step();
        rst = 1'b0;
        step();
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        s_valid = 1'b0;
        $display("reset mid-input: busy=%0d", busy);

`ifdef GRU_LOADER_CHECKSUM_EN
        load(1'b0, NP, 1);
        chk("bad_sum_error", {31'd0, error}, 32'd1);
        chk("bad_sum_done", {31'd0, done}, 32'd0);
        step();
        $display("checksum off by one: error=%0d", error);
`endif

        repeat (2) step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gru_weight_loader.md
# gru_weight_loader

Streaming writer that fills one GRU layer's coefficient memories (bias, input weights, recurrent weights) from a 32-bit word stream. It is the producer side of the coefficient memories that `gru`-layer datapaths read, replacing simulation-only file preload with a run-time load path from the host/DMA interface. It validates a header, sequences the three regions in the fixed order the GRU datapath indexes them (gate-major, `stride` = 3N), and reports completion or error.

## Interface
- `N`, 24, number of GRU units (state width in words)
- `M`, 24, number of input features
- `LAYER_ID`, 8'd1, expected layer id in the header
- `ADDR_W`, 16, write address width; must hold `3*N*M - 1`
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, asynchronous, active-high
- `start`  input  1  one-cycle pulse: begin or restart a load
- `s_data`  input  32  stream word
- `s_valid`  input  1  `s_data` valid
- `s_ready`  output  1  loader accepts a word this cycle
- `wr_en`  output  1  memory write strobe
- `wr_sel`  output  2  region: 0 bias, 1 input weights, 2 recurrent weights
- `wr_addr`  output  ADDR_W  word address within region
- `wr_data`  output  32  word to write
- `busy`  output  1  load in progress
- `done`  output  1  last load completed correctly (level)
- `error`  output  1  last load aborted on error (level)

## Operation
- Beat accepted when `s_valid && s_ready`. `s_ready` = 1 only in HEADER, BIAS, INPUT, RECUR, CHECK.
- States: IDLE → HEADER → BIAS → INPUT → RECUR → (CHECK) → DONE; any → ERROR on fault.
- IDLE: `s_ready`=0. `start` → HEADER, clears `done`/`error`, zeroes counter and checksum.
- HEADER: one beat. Valid iff `s_data[31:16]==16'hC0DE` and `s_data[15:8]==LAYER_ID`; `[7:0]` ignored. Valid → BIAS, else → ERROR. Header is not written.
- BIAS: 3N beats, `wr_sel`=0, `wr_addr` 0..3N-1.
- INPUT: 3N·M beats, `wr_sel`=1, `wr_addr` 0..3N·M-1.
- RECUR: 3N·N beats, `wr_sel`=2, `wr_addr` 0..3N·N-1.
- Single address counter; resets to 0 on each region transition (on the beat writing the region's last address).
- DONE: `done`=1, `busy`=0, `s_ready`=0; held until `start` or `rst`.
- ERROR: `error`=1, `busy`=0, `s_ready`=0; held until `start` or `rst`. No further writes.
- `start` in any state (including mid-load) aborts and re-enters HEADER next cycle; already-written words are left as-is; the beat presented in the `start` cycle is not accepted.
- `busy`=1 in HEADER..CHECK.

## Timing
- Reset values: `s_ready`=0, `wr_en`=0, `wr_sel`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, `error`=0; state IDLE.
- Write port registered: beat accepted in cycle t → `wr_en`=1 with its sel/addr/data in cycle t+1; `wr_en`=0 otherwise.
- Full-rate: one word per cycle with `s_valid` held high; gaps in `s_valid` insert `wr_en`=0 cycles, no data loss.
- `done` rises in the cycle the final RECUR write is on the port (without checksum) or the cycle after the checksum beat (with checksum).
- Default total payload: 72 + 1728 + 1728 = 3528 words; minimum load time header + 3528 beats + 1.
- `rst` mid-load: immediate return to reset values; pending write dropped.

## Configuration
- `GRU_LOADER_CHECKSUM_EN` defined: after RECUR, CHECK accepts one beat; compared to the 32-bit modulo-2^32 sum of all payload words (header excluded). Match → DONE, mismatch → ERROR. Checksum beat not written.
- Not defined: no CHECK state; RECUR's last beat → DONE directly.

## Test plan
- Reset then idle: `rst` pulse with `s_valid`=1 → all outputs 0, no `wr_en`, `s_ready`=0.
- Full load, N=M=24, header 32'hC0DE0100, payload word k = k → 72 writes sel 0 addr 0..71, 1728 sel 1, 1728 sel 2, each `wr_data`=k, latency 1; `done`=1 (checksum: send 32'd6221628 → `done`=1).
- Bad header 32'hBEEF0100 and 32'hC0DE0200 → `error`=1, zero `wr_en`, `s_ready`=0 until `start`.
- Random `s_valid` gaps (30% low) → write sequence identical to full-rate case, addresses contiguous per region.
- `start` asserted after 100 payload beats → returns to HEADER, second full load completes with `done`=1 and addresses restarting at 0 sel 0.
- Checksum build, checksum off by 1 → `error`=1, `done`=0; `rst` mid-INPUT → all outputs 0 next cycle.
